// File: rtl/cmd_dispatcher.sv
// Command dispatcher: holds one decoded command until its destination (and source, for
// COPY/ADD_VEC) are free in the busy scoreboard, then issues it over a valid/ready handshake.
module cmd_dispatcher #(
  parameter int unsigned UNIT_COUNT = 4,
  parameter int unsigned UNIT_ID_W  = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [2:0]            dec_op,
  input  logic [1:0]            dec_comp,
  input  logic [UNIT_ID_W-1:0]  dec_unit_id,
  input  logic [UNIT_ID_W-1:0]  dec_src_unit_id,
  input  logic [1:0]            dec_err,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [2:0]            issue_op,
  output logic [1:0]            issue_comp,
  output logic [UNIT_ID_W-1:0]  issue_unit_id,
  output logic [UNIT_ID_W-1:0]  issue_src_id,
  input  logic [UNIT_COUNT-1:0] unit_done,
  output logic [UNIT_COUNT-1:0] unit_busy,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  all_idle
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_e;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_COPY    = 3'b100;
  localparam logic [2:0] OP_ADD_VEC = 3'b101;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            comp_q, comp_d;
  logic [UNIT_ID_W-1:0]  unit_q, unit_d;
  logic [UNIT_ID_W-1:0]  src_q, src_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [UNIT_COUNT-1:0] unit_busy_q, unit_busy_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  bad_cmd;
  logic                  handshake;
  logic                  hazard;
  logic [UNIT_COUNT-1:0] dst_mask;
  logic [UNIT_COUNT-1:0] src_mask;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    comp_d        = comp_q;
    unit_d        = unit_q;
    src_d         = src_q;
    issue_valid_d = issue_valid_q;
    err_pulse_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    stall_cnt_d   = stall_cnt_q;

    bad_cmd   = (dec_err != 2'b00) || (32'(dec_unit_id) >= UNIT_COUNT) || (dec_op[2:1] == 2'b11);
    handshake = issue_valid_q && issue_ready;
    // Masks are built by shifting so an out-of-range ID simply yields an empty mask.
    dst_mask  = UNIT_COUNT'(1) << unit_q;
    src_mask  = UNIT_COUNT'(1) << src_q;
    hazard    = (|(unit_busy_q & dst_mask)) ||
                (((op_q == OP_COPY) || (op_q == OP_ADD_VEC)) && (|(unit_busy_q & src_mask)));

    // Set after clear so a same-cycle issue and done on one unit leaves it busy.
    unit_busy_d = (unit_busy_q & ~unit_done) | (handshake ? dst_mask : '0);

    case (state_q)
      S_IDLE: begin
        if (dec_valid) begin
          if (bad_cmd) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end else if (dec_op != OP_NOP) begin
            op_d    = dec_op;
            comp_d  = dec_comp;
            unit_d  = dec_unit_id;
            src_d   = dec_src_unit_id;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (hazard) begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
          issue_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          issue_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: holding registers are reset too, so no stale command is presented after reset.
      state_q       <= S_IDLE;
      op_q          <= '0;
      comp_q        <= '0;
      unit_q        <= '0;
      src_q         <= '0;
      issue_valid_q <= 1'b0;
      unit_busy_q   <= '0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      comp_q        <= comp_d;
      unit_q        <= unit_d;
      src_q         <= src_d;
      issue_valid_q <= issue_valid_d;
      unit_busy_q   <= unit_busy_d;
      err_pulse_q   <= err_pulse_d;
      err_cnt_q     <= err_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign dec_ready     = (state_q == S_IDLE);
  assign all_idle      = (state_q == S_IDLE) && (unit_busy_q == '0);
  assign issue_valid   = issue_valid_q;
  assign issue_op      = op_q;
  assign issue_comp    = comp_q;
  assign issue_unit_id = unit_q;
  assign issue_src_id  = src_q;
  assign unit_busy     = unit_busy_q;
  assign err_pulse     = err_pulse_q;
  assign err_cnt       = err_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: a wide-counter instance plus a CNT_W=2 instance on the
// same stimulus for saturation; 3-bit unit IDs so an out-of-range ID can be driven.
module tb_cmd_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [2:0] dec_op;
  logic [1:0] dec_comp;
  logic [2:0] dec_unit_id;
  logic [2:0] dec_src_unit_id;
  logic [1:0] dec_err;
  logic       issue_ready;
  logic [3:0] unit_done;

  logic       dec_ready, issue_valid, err_pulse, all_idle;
  logic [2:0] issue_op, issue_unit_id, issue_src_id;
  logic [1:0] issue_comp;
  logic [3:0] unit_busy;
  logic [7:0] err_cnt, stall_cnt;

  logic       s_dec_ready, s_issue_valid, s_err_pulse, s_all_idle;
  logic [2:0] s_issue_op, s_issue_unit_id, s_issue_src_id;
  logic [1:0] s_issue_comp;
  logic [3:0] s_unit_busy;
  logic [1:0] s_err_cnt, s_stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  cmd_dispatcher #(.UNIT_COUNT(4), .UNIT_ID_W(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_comp(dec_comp), .dec_unit_id(dec_unit_id), .dec_src_unit_id(dec_src_unit_id),
    .dec_err(dec_err), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_comp(issue_comp), .issue_unit_id(issue_unit_id),
    .issue_src_id(issue_src_id), .unit_done(unit_done), .unit_busy(unit_busy),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .stall_cnt(stall_cnt), .all_idle(all_idle)
  );

  cmd_dispatcher #(.UNIT_COUNT(4), .UNIT_ID_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(s_dec_ready), .dec_op(dec_op),
    .dec_comp(dec_comp), .dec_unit_id(dec_unit_id), .dec_src_unit_id(dec_src_unit_id),
    .dec_err(dec_err), .issue_valid(s_issue_valid), .issue_ready(issue_ready),
    .issue_op(s_issue_op), .issue_comp(s_issue_comp), .issue_unit_id(s_issue_unit_id),
    .issue_src_id(s_issue_src_id), .unit_done(unit_done), .unit_busy(s_unit_busy),
    .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .stall_cnt(s_stall_cnt), .all_idle(s_all_idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] comp, input logic [2:0] unit,
                       input logic [2:0] src, input logic [1:0] err);
    dec_valid       = 1'b1;
    dec_op          = op;
    dec_comp        = comp;
    dec_unit_id     = unit;
    dec_src_unit_id = src;
    dec_err         = err;
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; dec_op = '0; dec_comp = '0; dec_unit_id = '0;
    dec_src_unit_id = '0; dec_err = '0; issue_ready = 1'b0; unit_done = '0;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 32'(issue_valid), 0);
    check("rst_busy", 32'(unit_busy), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_all_idle", 32'(all_idle), 1);
    rst = 1'b0;
    tick();
    check("rel_ready", 32'(dec_ready), 1);

    // T1: COMPUTE to unit 2, everything idle
    issue_ready = 1'b1;
    drive(3'd3, 2'd2, 3'd2, 3'd0, 2'd0);
    tick();
    dec_valid = 1'b0;
    check("t1_wait_valid", 32'(issue_valid), 0);
    check("t1_wait_ready", 32'(dec_ready), 0);
    tick();
    check("t1_valid", 32'(issue_valid), 1);
    check("t1_unit", 32'(issue_unit_id), 2);
    check("t1_comp", 32'(issue_comp), 2);
    check("t1_op", 32'(issue_op), 3);
    tick();
    check("t1_post_valid", 32'(issue_valid), 0);
    check("t1_busy", 32'(unit_busy), 32'h4);
    check("t1_ready", 32'(dec_ready), 1);
    check("t1_all_idle", 32'(all_idle), 0);

    // T2 setup: retire unit 2 while accepting COMPUTE to unit 3
    unit_done = 4'b0100;
    drive(3'd3, 2'd0, 3'd3, 3'd0, 2'd0);
    tick();
    unit_done = '0;
    dec_valid = 1'b0;
    check("t2_clr_busy", 32'(unit_busy), 0);
    repeat (2) tick();
    check("t2_setup_busy", 32'(unit_busy), 32'h8);

    // T2: COPY dst=1 src=3 stalls on the busy source
    drive(3'd4, 2'd0, 3'd1, 3'd3, 2'd0);
    tick();
    dec_valid = 1'b0;
    repeat (3) tick();
    check("t2_stall3", 32'(stall_cnt), 3);
    check("t2_sat_stall3", 32'(s_stall_cnt), 3);
    check("t2_hold_valid", 32'(issue_valid), 0);
    check("t2_hold_ready", 32'(dec_ready), 0);
    unit_done = 4'b1000;
    tick();
    unit_done = '0;
    check("t2_n1_valid", 32'(issue_valid), 0);
    check("t2_n1_busy", 32'(unit_busy), 0);
    tick();
    check("t2_valid", 32'(issue_valid), 1);
    check("t2_unit", 32'(issue_unit_id), 1);
    check("t2_src", 32'(issue_src_id), 3);
    check("t2_op", 32'(issue_op), 4);
    check("t2_stall", 32'(stall_cnt), 4);
    check("t2_sat_stall", 32'(s_stall_cnt), 3);
    tick();
    check("t2_busy_dst_only", 32'(unit_busy), 32'h2);

    // T3: three kinds of error drop, then a NOP
    drive(3'd3, 2'd0, 3'd0, 3'd0, 2'd2);
    tick();
    check("t3_e1_pulse", 32'(err_pulse), 1);
    check("t3_e1_cnt", 32'(err_cnt), 1);
    check("t3_e1_ready", 32'(dec_ready), 1);
    drive(3'd3, 2'd0, 3'd4, 3'd0, 2'd0);
    tick();
    check("t3_e2_pulse", 32'(err_pulse), 1);
    check("t3_e2_cnt", 32'(err_cnt), 2);
    drive(3'd7, 2'd0, 3'd0, 3'd0, 2'd0);
    tick();
    check("t3_e3_pulse", 32'(err_pulse), 1);
    check("t3_e3_cnt", 32'(err_cnt), 3);
    check("t3_e3_sat_cnt", 32'(s_err_cnt), 3);
    drive(3'd0, 2'd0, 3'd0, 3'd0, 2'd0);
    tick();
    dec_valid = 1'b0;
    check("t3_nop_pulse", 32'(err_pulse), 0);
    check("t3_nop_cnt", 32'(err_cnt), 3);
    check("t3_nop_ready", 32'(dec_ready), 1);
    tick();
    check("t3_nop_valid", 32'(issue_valid), 0);
    check("t3_nop_busy", 32'(unit_busy), 32'h2);

    // T4: issue_ready held low for 5 cycles while decoder inputs change
    issue_ready = 1'b0;
    drive(3'd3, 2'd1, 3'd0, 3'd0, 2'd0);
    tick();
    dec_valid = 1'b0; dec_op = 3'd5; dec_unit_id = 3'd3; dec_comp = 2'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", 32'(issue_valid), 1);
      check("t4_unit", 32'(issue_unit_id), 0);
      check("t4_comp", 32'(issue_comp), 1);
      check("t4_op", 32'(issue_op), 3);
      check("t4_ready", 32'(dec_ready), 0);
      tick();
    end
    issue_ready = 1'b1;
    tick();
    check("t4_busy", 32'(unit_busy), 32'h3);
    check("t4_post_valid", 32'(issue_valid), 0);
    check("t4_post_ready", 32'(dec_ready), 1);

    // T5: reset while presenting a command with busy=0011
    issue_ready = 1'b0;
    drive(3'd3, 2'd0, 3'd2, 3'd0, 2'd0);
    tick();
    dec_valid = 1'b0;
    tick();
    check("t5_pre_valid", 32'(issue_valid), 1);
    check("t5_pre_busy", 32'(unit_busy), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 32'(issue_valid), 0);
    check("t5_busy", 32'(unit_busy), 0);
    check("t5_err_cnt", 32'(err_cnt), 0);
    check("t5_stall_cnt", 32'(stall_cnt), 0);
    check("t5_sat_err_cnt", 32'(s_err_cnt), 0);
    check("t5_all_idle", 32'(all_idle), 1);
    check("t5_ready", 32'(dec_ready), 1);

    // T6: err_cnt saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      drive(3'd3, 2'd0, 3'd0, 3'd0, 2'd1);
      tick();
      check("t6_err_cnt", 32'(err_cnt), 32'(i + 1));
      check("t6_sat_err_cnt", 32'(s_err_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    dec_valid = 1'b0;

    // T6: same-cycle handshake and unit_done on unit 1 leaves it busy
    issue_ready = 1'b1;
    drive(3'd3, 2'd0, 3'd1, 3'd0, 2'd0);
    tick();
    dec_valid = 1'b0;
    tick();
    unit_done = 4'b0010;
    tick();
    unit_done = '0;
    check("t6_set_wins", 32'(unit_busy), 32'h2);

    drive(3'd3, 2'd0, 3'd3, 3'd0, 2'd0);
    tick();
    dec_valid = 1'b0;
    repeat (2) tick();
    check("t6_busy_1010", 32'(unit_busy), 32'ha);

    // ADD_VEC with src == dst stalls on the destination; two dones clear together
    drive(3'd5, 2'd0, 3'd1, 3'd1, 2'd0);
    tick();
    dec_valid = 1'b0;
    tick();
    check("t6_av_stall1", 32'(stall_cnt), 1);
    check("t6_av_hold", 32'(issue_valid), 0);
    unit_done = 4'b1010;
    tick();
    unit_done = '0;
    check("t6_multi_done", 32'(unit_busy), 0);
    check("t6_av_stall2", 32'(stall_cnt), 2);
    tick();
    check("t6_av_valid", 32'(issue_valid), 1);
    check("t6_av_src", 32'(issue_src_id), 1);
    tick();
    check("t6_av_busy", 32'(unit_busy), 32'h2);
    check("t6_av_all_idle", 32'(all_idle), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
